// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: WB control field indices, default datapath
// widths and the hard-wired zero register index. The MEM/WB register and any
// later pipeline registers use the same WB field constants.
package cpu_pkg;

    // Bit positions inside the 2-bit WB control field
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int WB_W        = 2;

    // Default datapath geometry
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    // Architectural register that always reads as zero
    localparam int REG_ZERO = 0;

endpackage : cpu_pkg

// File: rtl/regfile_2r1w.sv
// Two-read / one-write general-purpose register file.
// r0 reads as zero and is never written. Reads are asynchronous.
// Optional feature macro WB_REGFILE_BYPASS_EN: when defined, a read of the
// register being written in the same cycle returns the incoming write data.
module regfile_2r1w #(
    parameter int NREG = cpu_pkg::NREG,
    parameter int DW   = cpu_pkg::DW,
    parameter int AW   = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2
);
    import cpu_pkg::*;

    logic [DW-1:0] r_regs [NREG];
    logic          w_commit;

    // Writes to r0 are dropped so that entry stays at its reset value
    assign w_commit = i_we && (i_waddr != AW'(REG_ZERO));

    // Storage array update: synchronous clear, otherwise one write per edge
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every entry is cleared on reset, which makes this a flop
            // array rather than an inferable RAM macro; that is intended here.
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read ports with r0 masking and optional write-through
    always_comb begin
        // NOTE: default assignments first so no path through this block
        // leaves an output unassigned and infers a latch.
        o_rdata1 = '0;
        o_rdata2 = '0;
        if (i_raddr1 != AW'(REG_ZERO)) begin
            o_rdata1 = r_regs[i_raddr1];
`ifdef WB_REGFILE_BYPASS_EN
            if (w_commit && (i_raddr1 == i_waddr)) begin
                o_rdata1 = i_wdata;
            end
`endif
        end
        if (i_raddr2 != AW'(REG_ZERO)) begin
            o_rdata2 = r_regs[i_raddr2];
`ifdef WB_REGFILE_BYPASS_EN
            if (w_commit && (i_raddr2 == i_waddr)) begin
                o_rdata2 = i_wdata;
            end
`endif
        end
    end

endmodule : regfile_2r1w

// File: rtl/wb_regfile.sv
// Writeback stage end: selects the writeback value from the MEM/WB register,
// commits it into the register file, exports the effective write to the
// forwarding unit and counts committed writes for debug.
// Optional feature macro WB_REGFILE_BYPASS_EN enables write-through bypass
// in the register file read ports.
module wb_regfile #(
    parameter int NREG = cpu_pkg::NREG,
    parameter int DW   = cpu_pkg::DW,
    parameter int AW   = cpu_pkg::AW,
    parameter int CW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    WB,
    input  logic [AW-1:0] Rd,
    input  logic [DW-1:0] MemData,
    input  logic [DW-1:0] ALUData,
    input  logic [AW-1:0] Rs,
    input  logic [AW-1:0] Rt,
    output logic [DW-1:0] ReadData1,
    output logic [DW-1:0] ReadData2,
    output logic [DW-1:0] WBData,
    output logic [AW-1:0] WBRd,
    output logic          WBEn,
    output logic [CW-1:0] WriteCount
);
    import cpu_pkg::*;

    logic [DW-1:0] w_wb_data;
    logic          w_wb_en;
    logic [CW-1:0] r_write_count;

    // Writeback select and effective enable; independent of rst by design
    assign w_wb_data = WB[WB_MEMTOREG] ? MemData : ALUData;
    assign w_wb_en   = WB[WB_REGWRITE] && (Rd != AW'(REG_ZERO));

    assign WBData     = w_wb_data;
    assign WBRd       = Rd;
    assign WBEn       = w_wb_en;
    assign WriteCount = r_write_count;

    regfile_2r1w #(
        .NREG (NREG),
        .DW   (DW),
        .AW   (AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_wb_en),
        .i_waddr  (Rd),
        .i_wdata  (w_wb_data),
        .i_raddr1 (Rs),
        .i_raddr2 (Rt),
        .o_rdata1 (ReadData1),
        .o_rdata2 (ReadData2)
    );

    // Retired-write counter; wraps silently at 2^CW
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_write_count <= '0;
        end else if (w_wb_en) begin
            r_write_count <= r_write_count + CW'(1);
        end
    end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile. A behavioural register-file model is
// compared against the DUT every cycle; directed vectors add literal checks.
// A second instance with a 4-bit counter exercises counter wrap.
// Define WB_REGFILE_BYPASS_EN for both RTL and bench to test the bypass build.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  WB;
    logic [4:0]  Rd, Rs, Rt;
    logic [31:0] MemData, ALUData;

    logic [31:0] rd1, rd2, wbdata, wc;
    logic [4:0]  wbrd;
    logic        wben;
    logic [31:0] rd1_w, rd2_w, wbdata_w;
    logic [4:0]  wbrd_w;
    logic        wben_w;
    logic [3:0]  wc_w;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .WB(WB), .Rd(Rd), .MemData(MemData),
        .ALUData(ALUData), .Rs(Rs), .Rt(Rt), .ReadData1(rd1),
        .ReadData2(rd2), .WBData(wbdata), .WBRd(wbrd), .WBEn(wben),
        .WriteCount(wc)
    );

    wb_regfile #(.CW(4)) dut_w (
        .clk(clk), .rst(rst), .WB(WB), .Rd(Rd), .MemData(MemData),
        .ALUData(ALUData), .Rs(Rs), .Rt(Rt), .ReadData1(rd1_w),
        .ReadData2(rd2_w), .WBData(wbdata_w), .WBRd(wbrd_w), .WBEn(wben_w),
        .WriteCount(wc_w)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    bit          m_valid = 0;

    function automatic logic [31:0] m_wbdata();
        return WB[0] ? MemData : ALUData;
    endfunction

    function automatic logic m_wben();
        return WB[1] && (Rd != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (m_wben() && a == Rd) return m_wbdata();
`endif
        return m_regs[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_cnt   = 32'h0;
            m_valid = 1;
        end else if (m_wben()) begin
            m_regs[Rd] = m_wbdata();
            m_cnt      = m_cnt + 32'd1;
        end
    end

    // Every-cycle comparison on the falling edge (inputs are stable there)
    always @(negedge clk) begin
        if (m_valid) begin
            check("ReadData1",   rd1,    m_read(Rs));
            check("ReadData2",   rd2,    m_read(Rt));
            check("WBData",      wbdata, m_wbdata());
            check("WBRd",        {27'd0, wbrd}, {27'd0, Rd});
            check("WBEn",        {31'd0, wben}, {31'd0, m_wben()});
            check("WriteCount",  wc,     m_cnt);
            check("w.ReadData1", rd1_w,  m_read(Rs));
            check("w.WriteCount", {28'd0, wc_w}, {28'd0, m_cnt[3:0]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [31:0] exp_pre;

    initial begin
`ifdef WB_REGFILE_BYPASS_EN
        exp_pre = 32'h22;
`else
        exp_pre = 32'h11;
`endif
        rst = 1'b1; WB = 2'b00; Rd = '0; Rs = '0; Rt = '0;
        MemData = '0; ALUData = '0;
        @(negedge clk); #1;
        cyc();

        // Reset then read
        rst = 1'b0; Rs = 5'd5; Rt = 5'd31;
        #1;
        check("rst_rd1", rd1, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        check("rst_wc",  wc,  32'h0);

        // ALU writeback
        WB = 2'b10; Rd = 5'd8; ALUData = 32'h0000_1234; MemData = 32'hDEAD_BEEF;
        #1;
        check("alu_wbdata", wbdata, 32'h0000_1234);
        check("alu_wben",   {31'd0, wben}, 32'd1);
        cyc();
        WB = 2'b00; Rs = 5'd8;
        #1;
        check("alu_rd1", rd1, 32'h0000_1234);
        check("alu_wc",  wc,  32'd1);

        // Load writeback, then write to r0
        WB = 2'b11; Rd = 5'd9; MemData = 32'hCAFE_F00D;
        cyc();
        WB = 2'b10; Rd = 5'd0; ALUData = 32'hFFFF_FFFF;
        #1;
        check("r0_wben", {31'd0, wben}, 32'd0);
        cyc();
        WB = 2'b00; Rt = 5'd9; Rs = 5'd0;
        #1;
        check("ld_rd2", rd2, 32'hCAFE_F00D);
        check("r0_rd1", rd1, 32'h0);
        check("ld_wc",  wc,  32'd2);

        // Same-cycle read/write hazard
        WB = 2'b10; Rd = 5'd3; ALUData = 32'h11;
        cyc();
        ALUData = 32'h22; Rs = 5'd3; Rt = 5'd3;
        #1;
        check("haz_pre_rd1", rd1, exp_pre);
        check("haz_pre_rd2", rd2, exp_pre);
        cyc();
        WB = 2'b00;
        #1;
        check("haz_post_rd1", rd1, 32'h22);
        check("haz_post_rd2", rd2, 32'h22);
        check("haz_wc",       wc,  32'd4);

        // Reset mid-stream with a write presented on the same edge
        rst = 1'b1; WB = 2'b10; Rd = 5'd4; ALUData = 32'h55;
        #1;
        check("rstw_wbdata", wbdata, 32'h55);
        cyc();
        rst = 1'b0; WB = 2'b00; Rs = 5'd4; Rt = 5'd8;
        #1;
        check("rstw_rd1", rd1, 32'h0);
        check("rstw_rd2", rd2, 32'h0);
        check("rstw_wc",  wc,  32'h0);

        // Sixteen committed writes: 4-bit counter wraps to zero
        for (int i = 0; i < 16; i++) begin
            WB = 2'b10; Rd = 5'(i + 1); ALUData = 32'h100 + 32'(i);
            cyc();
        end
        WB = 2'b00; Rs = 5'd16; Rt = 5'd1;
        #1;
        check("wrap_wc4",  {28'd0, wc_w}, 32'd0);
        check("wrap_wc32", wc,  32'd16);
        check("wrap_rd1",  rd1, 32'h10F);
        check("wrap_rd2",  rd2, 32'h100);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-end consumer of the MEM/WB pipeline register in the 5-stage pipelined CPU.
- Takes the latched WB control, destination register, memory data and ALU result, and selects the writeback value.
- Commits that value into a 32x32 general-purpose register file that the ID stage reads through two asynchronous read ports.
- Also exports the selected writeback value, register and enable to the forwarding unit, and keeps a retired-write counter for debug.

Parameters:
- NREG, 32, number of architectural registers; must be a power of two.
- DW, 32, data width of the registers and datapath.
- AW, 5, register address width; equals log2(NREG).
- CW, 32, width of the retired-write counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- WB  in  2  WB control from MEM/WB; bit1 = RegWrite, bit0 = MemtoReg
- Rd  in  AW  destination register from MEM/WB
- MemData  in  DW  load data from MEM/WB
- ALUData  in  DW  ALU result from MEM/WB
- Rs  in  AW  ID-stage read address 1
- Rt  in  AW  ID-stage read address 2
- ReadData1  out  DW  register data for Rs
- ReadData2  out  DW  register data for Rt
- WBData  out  DW  selected writeback value (to forwarding unit)
- WBRd  out  AW  effective writeback register (to forwarding unit)
- WBEn  out  1  effective write enable (to forwarding unit)
- WriteCount  out  CW  number of committed register writes

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high, named rst; it is sampled only on the rising edge of clk.
- Writeback select (combinational):
  - WBData = MemData when WB[0] = 1, else ALUData.
  - WBEn = WB[1] & (Rd != 0).
  - WBRd = Rd.
- Commit: on a rising clk edge with rst = 0 and WBEn = 1, regs[Rd] <= WBData. Writes to r0 are dropped, so WBEn = 0 and the counter does not advance.
- r0 always reads 0 and is never stored nonzero.
- Reads are asynchronous: ReadDataN = (addr == 0) ? 0 : regs[addr], plus the bypass rule below.
- Counter: WriteCount increments by 1 on each committed write and wraps from 2^CW-1 to 0 with no flag.
- Reset: on a clk edge with rst = 1, all NREG registers clear to 0 and WriteCount clears to 0. Any write presented in that cycle is discarded, including rst asserted mid-stream. After reset, ReadData1 = ReadData2 = 0 for all addresses.
- Output values during and after reset:
  - WBData, WBRd and WBEn are combinational from the inputs and unaffected by rst.
  - ReadData1/2 reflect the cleared array from the cycle after the reset edge.
- Same-cycle read/write of the same register (Rs or Rt == Rd, WBEn = 1): behaviour is set by the optional feature below.
- Both read ports may address the same register; each is resolved independently.
- Latency: write-to-read-visible is 1 edge without bypass and 0 cycles with bypass.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: write-through bypass. If WBEn = 1 and Rs == Rd (Rs != 0), ReadData1 = WBData combinationally; ReadData2 likewise for Rt. This removes the split-cycle write-then-read hazard.
- Undefined: no bypass. ReadDataN returns the old array content until the edge commits. The hazard unit must then cover the 3-cycle-apart case with a stall or a forward.

Decomposition:
- Shared package cpu_pkg holds:
  - WB field index constants WB_REGWRITE = 1 and WB_MEMTOREG = 0.
  - Default widths (DW, AW, NREG).
  - Constant REG_ZERO = 0.
- The MEM/WB register and later pipeline registers reuse the same WB field constants.
- One natural sub-module: regfile_2r1w, the storage array with reset, r0 masking and optional bypass. The top adds the writeback mux, forwarding outputs and counter.

Test Plan:
- Reset then read: rst = 1 for 1 edge; Rs = 5, Rt = 31 -> ReadData1 = ReadData2 = 0, WriteCount = 0.
- ALU writeback: WB = 2'b10, Rd = 8, ALUData = 0x0000_1234, MemData = 0xDEAD_BEEF, one edge; then Rs = 8 -> ReadData1 = 0x0000_1234, WriteCount = 1.
- Load writeback and r0 guard: WB = 2'b11, Rd = 9, MemData = 0xCAFE_F00D, one edge, then WB = 2'b10, Rd = 0, ALUData = 0xFFFF_FFFF, one edge -> Rt = 9 reads 0xCAFE_F00D; Rs = 0 reads 0; WBEn = 0 during the r0 write; WriteCount = 2.
- Same-cycle hazard: regs[3] = 0x11; present WB = 2'b10, Rd = 3, ALUData = 0x22, Rs = Rt = 3 before the edge -> ReadData1 = ReadData2 = 0x22 with WB_REGFILE_BYPASS_EN, 0x11 without; 0x22 after the edge in both builds.
- Reset mid-stream: WB = 2'b10, Rd = 4, ALUData = 0x55 with rst = 1 on the same edge -> regs[4] = 0, WriteCount = 0, WBData = 0x55 combinationally.
- Counter wrap (CW = 4 build): 16 committed writes -> WriteCount returns to 0.
